// File: rtl/readout_rx_pc_seq.sv
// Program-counter sequencer for the readout RX instruction path: opcode-driven next PC,
// nested hardware loop stack, halt/restart FSM, sticky stack error flags. Option: READOUT_RX_PC_FIRST_HOLD_EN.
module readout_rx_pc_seq #(
  parameter int          PC_WIDTH   = 11,
  parameter int          LOOP_DEPTH = 4,
  parameter int          CNT_WIDTH  = 8,
  parameter int unsigned START_PC   = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                update_pc,
  input  logic [2:0]                          op,
  input  logic [PC_WIDTH-1:0]                 target,
  input  logic [CNT_WIDTH-1:0]                loop_cnt,
  output logic [PC_WIDTH-1:0]                 PC,
  output logic                                halted,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]     loop_level,
  output logic                                pc_wrap,
  output logic                                stack_ovf,
  output logic                                stack_udf
);

  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
  localparam logic [LVL_W-1:0]    LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(LOOP_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(START_PC);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [2:0] OP_JUMP    = 3'd1;
  localparam logic [2:0] OP_PUSH    = 3'd2;
  localparam logic [2:0] OP_END     = 3'd3;
  localparam logic [2:0] OP_HALT    = 3'd4;
  localparam logic [2:0] OP_RESTART = 3'd5;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   r_body [LOOP_DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt  [LOOP_DEPTH];
  logic [LVL_W-1:0]      r_lvl;
  logic                  r_wrap;
  logic                  r_ovf;
  logic                  r_udf;

  logic [PC_WIDTH-1:0]   w_pc_inc;
  logic                  w_wrap;
  logic                  w_full;
  logic                  w_empty;
  logic [IDX_W-1:0]      w_top;
  logic [IDX_W-1:0]      w_push_idx;
  logic [CNT_WIDTH-1:0]  w_cnt_push;
  logic                  w_act;

  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_wrap     = &r_pc;
  assign w_full     = (r_lvl == LVL_FULL);
  assign w_empty    = (r_lvl == '0);
  assign w_top      = IDX_W'(r_lvl - LVL_ONE);
  assign w_push_idx = IDX_W'(r_lvl);
  assign w_cnt_push = (loop_cnt == '0) ? CNT_ONE : loop_cnt;

`ifdef READOUT_RX_PC_FIRST_HOLD_EN
  // Cleared by reset and RESTART; the strobe that sets it is swallowed so memory can fetch START_PC.
  logic r_armed;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (update_pc) begin
      r_armed <= r_armed ? (op != OP_RESTART) : 1'b1;
    end
  end
  assign w_act = r_armed;
`else
  assign w_act = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= PC_START;
      r_lvl   <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        r_body[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_wrap <= 1'b0;
      if (update_pc && w_act) begin
        if (op == OP_RESTART) begin
          r_state <= ST_RUN;
          r_pc    <= PC_START;
          r_lvl   <= '0;
          r_ovf   <= 1'b0;
          r_udf   <= 1'b0;
          for (int i = 0; i < LOOP_DEPTH; i++) begin
            r_body[i] <= '0;
            r_cnt[i]  <= '0;
          end
        end else if (r_state == ST_RUN) begin
          case (op)
            OP_JUMP: r_pc <= target;
            OP_PUSH: begin
              if (!w_full) begin
                r_body[w_push_idx] <= w_pc_inc;
                r_cnt[w_push_idx]  <= w_cnt_push;
                r_lvl              <= r_lvl + LVL_ONE;
              end else begin
                r_ovf <= 1'b1;
              end
              r_pc   <= w_pc_inc;
              r_wrap <= w_wrap;
            end
            OP_END: begin
              if (w_empty) begin
                r_udf  <= 1'b1;
                r_pc   <= w_pc_inc;
                r_wrap <= w_wrap;
              end else if (r_cnt[w_top] > CNT_ONE) begin
                r_cnt[w_top] <= r_cnt[w_top] - CNT_ONE;
                r_pc         <= r_body[w_top];
              end else begin
                r_cnt[w_top]  <= '0;
                r_body[w_top] <= '0;
                r_lvl         <= r_lvl - LVL_ONE;
                r_pc          <= w_pc_inc;
                r_wrap        <= w_wrap;
              end
            end
            OP_HALT: r_state <= ST_HALT;
            default: begin
              r_pc   <= w_pc_inc;
              r_wrap <= w_wrap;
            end
          endcase
        end
      end
    end
  end

  assign PC         = r_pc;
  assign halted     = (r_state == ST_HALT);
  assign loop_level = r_lvl;
  assign pc_wrap    = r_wrap;
  assign stack_ovf  = r_ovf;
  assign stack_udf  = r_udf;

endmodule

// File: tb/tb_readout_rx_pc_seq.sv
// Directed-vector bench for readout_rx_pc_seq (default parameters, PC_WIDTH=11, LOOP_DEPTH=4).
module tb_readout_rx_pc_seq;

  localparam logic [2:0] OP_NEXT    = 3'd0;
  localparam logic [2:0] OP_JUMP    = 3'd1;
  localparam logic [2:0] OP_PUSH    = 3'd2;
  localparam logic [2:0] OP_END     = 3'd3;
  localparam logic [2:0] OP_HALT    = 3'd4;
  localparam logic [2:0] OP_RESTART = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        update_pc;
  logic [2:0]  op;
  logic [10:0] target;
  logic [7:0]  loop_cnt;
  logic [10:0] PC;
  logic        halted;
  logic [2:0]  loop_level;
  logic        pc_wrap;
  logic        stack_ovf;
  logic        stack_udf;

  int n_vec = 0;
  int n_err = 0;

  readout_rx_pc_seq dut (
    .clk(clk), .rst(rst), .update_pc(update_pc), .op(op), .target(target),
    .loop_cnt(loop_cnt), .PC(PC), .halted(halted), .loop_level(loop_level),
    .pc_wrap(pc_wrap), .stack_ovf(stack_ovf), .stack_udf(stack_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [10:0] t, input logic [7:0] c);
    @(negedge clk);
    update_pc = 1'b1;
    op        = o;
    target    = t;
    loop_cnt  = c;
    @(posedge clk);
    #1;
    update_pc = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    update_pc = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Absorbs the swallowed first strobe when the hold option is built in.
  task automatic prime(input int exp_pc);
`ifdef READOUT_RX_PC_FIRST_HOLD_EN
    step(OP_NEXT, 11'd0, 8'd0);
    chk("first_hold_pc", int'(PC), exp_pc);
`else
    if (exp_pc < 0) $display("unexpected pc argument %0d", exp_pc);
`endif
  endtask

  initial begin
    rst = 1'b1; update_pc = 1'b0; op = OP_NEXT; target = '0; loop_cnt = '0;
    #3;
    chk("rst_pc", int'(PC), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_level", int'(loop_level), 0);
    chk("rst_wrap", int'(pc_wrap), 0);
    chk("rst_ovf", int'(stack_ovf), 0);
    chk("rst_udf", int'(stack_udf), 0);
    @(negedge clk);
    rst = 1'b0;
    prime(0);

    // sequential advance and idle gaps
    for (int i = 1; i <= 5; i++) begin
      step(OP_NEXT, 11'd0, 8'd0);
      chk("next_pc", int'(PC), i);
    end
    idle();
    idle();
    chk("gap_pc", int'(PC), 5);
    chk("gap_wrap", int'(pc_wrap), 0);

    // wrap at the top of the address space
    step(OP_JUMP, 11'd2047, 8'd0);
    chk("jump_pc", int'(PC), 2047);
    chk("jump_nowrap", int'(pc_wrap), 0);
    step(OP_NEXT, 11'd0, 8'd0);
    chk("wrap_pc", int'(PC), 0);
    chk("wrap_pulse", int'(pc_wrap), 1);
    idle();
    chk("wrap_one_cycle", int'(pc_wrap), 0);
    chk("wrap_hold_pc", int'(PC), 0);
    step(OP_JUMP, 11'd2047, 8'd0);
    step(OP_PUSH, 11'd0, 8'd1);
    chk("push_wrap_pc", int'(PC), 0);
    chk("push_wrap_pulse", int'(pc_wrap), 1);
    chk("push_wrap_level", int'(loop_level), 1);
    step(OP_END, 11'd0, 8'd0);
    chk("pop_wrap_pc", int'(PC), 1);
    chk("pop_wrap_level", int'(loop_level), 0);
    chk("pop_nowrap", int'(pc_wrap), 0);

    // loop of three iterations over body 11,12
    step(OP_JUMP, 11'd10, 8'd0);
    step(OP_PUSH, 11'd0, 8'd3);
    chk("loop_first_pc", int'(PC), 11);
    chk("loop_level1", int'(loop_level), 1);
    for (int k = 0; k < 3; k++) begin
      step(OP_NEXT, 11'd0, 8'd0);
      chk("loop_body_pc", int'(PC), 12);
      step(OP_END, 11'd0, 8'd0);
      chk("loop_end_pc", int'(PC), (k < 2) ? 11 : 13);
    end
    chk("loop_level0", int'(loop_level), 0);

    // count 0 behaves as a single pass
    step(OP_JUMP, 11'd10, 8'd0);
    step(OP_PUSH, 11'd0, 8'd0);
    chk("cnt0_push_pc", int'(PC), 11);
    step(OP_NEXT, 11'd0, 8'd0);
    step(OP_END, 11'd0, 8'd0);
    chk("cnt0_exit_pc", int'(PC), 13);
    chk("cnt0_level", int'(loop_level), 0);

    // stack overflow, restart, underflow
    step(OP_JUMP, 11'd100, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step(OP_PUSH, 11'd0, 8'd2);
      chk("nest_level", int'(loop_level), i);
    end
    chk("nest_no_ovf", int'(stack_ovf), 0);
    step(OP_PUSH, 11'd0, 8'd2);
    chk("ovf_flag", int'(stack_ovf), 1);
    chk("ovf_level", int'(loop_level), 4);
    chk("ovf_pc", int'(PC), 105);
    step(OP_RESTART, 11'd0, 8'd0);
    chk("restart_pc", int'(PC), 0);
    chk("restart_ovf", int'(stack_ovf), 0);
    chk("restart_level", int'(loop_level), 0);
    prime(0);
    step(OP_END, 11'd0, 8'd0);
    chk("udf_flag", int'(stack_udf), 1);
    chk("udf_pc", int'(PC), 1);

    // halt ignores everything but restart
    step(OP_JUMP, 11'd20, 8'd0);
    step(OP_HALT, 11'd0, 8'd0);
    chk("halt_flag", int'(halted), 1);
    chk("halt_pc", int'(PC), 20);
    step(OP_NEXT, 11'd0, 8'd0);
    chk("halt_next_pc", int'(PC), 20);
    step(OP_JUMP, 11'd5, 8'd0);
    chk("halt_jump_pc", int'(PC), 20);
    chk("halt_still", int'(halted), 1);
    chk("halt_udf_kept", int'(stack_udf), 1);
    step(OP_RESTART, 11'd0, 8'd0);
    chk("halt_restart_pc", int'(PC), 0);
    chk("halt_restart_flag", int'(halted), 0);
    chk("halt_restart_udf", int'(stack_udf), 0);
    prime(0);

    // asynchronous reset in the middle of a nested loop
    step(OP_JUMP, 11'd35, 8'd0);
    step(OP_PUSH, 11'd0, 8'd2);
    step(OP_PUSH, 11'd0, 8'd2);
    chk("mid_pc", int'(PC), 37);
    chk("mid_level", int'(loop_level), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", int'(PC), 0);
    chk("async_level", int'(loop_level), 0);
    chk("async_halted", int'(halted), 0);
    @(negedge clk);
    rst = 1'b0;
    prime(0);
    step(OP_END, 11'd0, 8'd0);
    chk("post_rst_udf", int'(stack_udf), 1);
    chk("post_rst_pc", int'(PC), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
